// File: rtl/alu_pkg.sv
// Shared ALU package: opcode width, logic-unit opcode enumeration and a small
// helper that turns a raw opcode field into the enumerated type.
//
// Contents:
//   OP_W    - opcode width used by every logic-unit opcode port
//   lopE    - enumerated logic-unit opcodes LOP_AND .. LOP_PASSA
//   toLop() - raw opcode bits -> lopE
package alu_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        LOP_AND   = 3'd0,
        LOP_OR    = 3'd1,
        LOP_XOR   = 3'd2,
        LOP_NOR   = 3'd3,
        LOP_NAND  = 3'd4,
        LOP_XNOR  = 3'd5,
        LOP_ANDN  = 3'd6,  // a & ~b
        LOP_PASSA = 3'd7
    } lopE;

    function automatic lopE toLop(input logic [OP_W-1:0] raw);
        return lopE'(raw);
    endfunction

endpackage

// File: rtl/logic_op_core.sv
// Combinational bitwise logic core shared by the pipelined logic unit and the
// immediate logic path. Purely position-for-position: no carries, no width
// growth, so the [0:WIDTH-1] (bit 0 = MSB) ordering needs no special care.
//
// Parameters:
//   WIDTH - operand/result width in bits (1..64)
// Ports:
//   a, b  - operands, bit 0 is MSB
//   op    - opcode (alu_pkg::lopE encoding)
//   res   - result, bit 0 is MSB
module logic_op_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [0:WIDTH-1] a,
    input  logic [0:WIDTH-1] b,
    input  logic [OP_W-1:0]  op,
    output logic [0:WIDTH-1] res
);

    lopE opE;

    assign opE = toLop(op);

    always_comb begin
        res = '0;
        case (opE)
            LOP_AND:   res = a & b;
            LOP_OR:    res = a | b;
            LOP_XOR:   res = a ^ b;
            LOP_NOR:   res = ~(a | b);
            LOP_NAND:  res = ~(a & b);
            LOP_XNOR:  res = ~(a ^ b);
            LOP_ANDN:  res = a & ~b;
            LOP_PASSA: res = a;
            default:   res = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshakes on both
// sides. S1 captures operands and opcode; S2 holds the computed result plus
// zero and parity flags. Full throughput with backpressure.
//
// Optional feature (macro LOGIC_UNIT_POPCNT_EN): adds out_popcnt, the number
// of 1 bits in out_res, registered in S2 with the flags.
//
// Parameters:
//   WIDTH - operand/result width (1..64)
//   OP_W  - opcode width, must equal alu_pkg::OP_W
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   in_valid / in_ready   - input handshake
//   in_a, in_b            - operands, bit 0 is MSB
//   in_op                 - operation select
//   out_valid / out_ready - output handshake
//   out_res               - result, bit 0 is MSB
//   out_zero, out_parity  - result is all zeros / XOR of all result bits
//   out_popcnt            - result population count (LOGIC_UNIT_POPCNT_EN only)
module logic_unit_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OP_W  = alu_pkg::OP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:WIDTH-1] in_a,
    input  logic [0:WIDTH-1] in_b,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:WIDTH-1] out_res,
    output logic             out_zero,
    output logic             out_parity
`ifdef LOGIC_UNIT_POPCNT_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] out_popcnt
`endif
);

    if (OP_W != alu_pkg::OP_W) begin : gOpWCheck
        $error("logic_unit_pipe: OP_W must equal alu_pkg::OP_W");
    end

    if (WIDTH < 1 || WIDTH > 64) begin : gWidthCheck
        $error("logic_unit_pipe: WIDTH must be in 1..64");
    end

    // ------------------------------------------------------------------
    // Handshake / advance control
    // ------------------------------------------------------------------
    logic s1ValidQ, s1ValidD;
    logic s2ValidQ, s2ValidD;
    logic inFire;
    logic s2Adv;

    // S2 may take the S1 beat when it is empty or is being drained this cycle.
    assign s2Adv    = s1ValidQ && (!s2ValidQ || out_ready);
    // Depends on out_ready but never on in_valid.
    assign in_ready = !s1ValidQ || s2Adv;
    assign inFire   = in_valid && in_ready;

    always_comb begin
        s1ValidD = s1ValidQ;
        if (inFire) begin
            s1ValidD = 1'b1;
        end else if (s2Adv) begin
            s1ValidD = 1'b0;
        end
    end

    always_comb begin
        s2ValidD = s2ValidQ;
        if (s2Adv) begin
            // Covers the drain-and-refill case: no bubble.
            s2ValidD = 1'b1;
        end else if (out_ready) begin
            s2ValidD = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stage S1: operand capture
    // ------------------------------------------------------------------
    logic [0:WIDTH-1] s1AQ;
    logic [0:WIDTH-1] s1BQ;
    logic [OP_W-1:0]  s1OpQ;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1ValidQ <= 1'b0;
            s1AQ     <= '0;
            s1BQ     <= '0;
            s1OpQ    <= '0;
        end else begin
            s1ValidQ <= s1ValidD;
            if (inFire) begin
                s1AQ  <= in_a;
                s1BQ  <= in_b;
                s1OpQ <= in_op;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage S2: compute, flag and register
    // ------------------------------------------------------------------
    logic [0:WIDTH-1] coreRes;
    logic             zeroD;
    logic             parityD;

    logic_op_core #(
        .WIDTH (WIDTH)
    ) uCore (
        .a   (s1AQ),
        .b   (s1BQ),
        .op  (s1OpQ),
        .res (coreRes)
    );

    assign zeroD   = ~|coreRes;
    assign parityD = ^coreRes;

    logic [0:WIDTH-1] resQ;
    logic             zeroQ;
    logic             parityQ;

    // Result registers only load on s2Adv, so they hold under stall and keep
    // their last value (deterministically) while the pipe is empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2ValidQ <= 1'b0;
            resQ     <= '0;
            zeroQ    <= 1'b1;
            parityQ  <= 1'b0;
        end else begin
            s2ValidQ <= s2ValidD;
            if (s2Adv) begin
                resQ    <= coreRes;
                zeroQ   <= zeroD;
                parityQ <= parityD;
            end
        end
    end

    assign out_valid  = s2ValidQ;
    assign out_res    = resQ;
    assign out_zero   = zeroQ;
    assign out_parity = parityQ;

`ifdef LOGIC_UNIT_POPCNT_EN
    localparam int unsigned PCW = $clog2(WIDTH + 1);

    logic [PCW-1:0] popD;
    logic [PCW-1:0] popQ;

    always_comb begin
        popD = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            popD = popD + PCW'(coreRes[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            popQ <= '0;
        end else if (s2Adv) begin
            popQ <= popD;
        end
    end

    assign out_popcnt = popQ;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: a WIDTH=32 instance driven by a
// vector table and directed sequences, and a WIDTH=8 instance driven with
// random traffic. Both are checked through expected-result queues.
module tb_logic_unit_pipe;
    import alu_pkg::*;

    localparam int unsigned PW32 = $clog2(33);
    localparam int unsigned PW8  = $clog2(9);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Truth-table reference: bit {a,b} indexes a 4-bit function per opcode.
    function automatic logic [63:0] modelRes(input logic [63:0] a, input logic [63:0] b,
                                             input logic [2:0] op);
        logic [3:0]  tt;
        logic [63:0] r;
        case (op)
            3'd0:    tt = 4'b1000;
            3'd1:    tt = 4'b1110;
            3'd2:    tt = 4'b0110;
            3'd3:    tt = 4'b0001;
            3'd4:    tt = 4'b0111;
            3'd5:    tt = 4'b1001;
            3'd6:    tt = 4'b0100;
            default: tt = 4'b1100;
        endcase
        for (int i = 0; i < 64; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    // ---------------- WIDTH=32 instance ----------------
    logic        inValid, inReady, outValid, outReady, outZero, outParity;
    logic [0:31] inA, inB, outRes;
    logic [2:0]  inOp;
`ifdef LOGIC_UNIT_POPCNT_EN
    logic [PW32-1:0] outPop;
`endif

    logic_unit_pipe #(.WIDTH(32)) dut32 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .in_a       (inA),
        .in_b       (inB),
        .in_op      (inOp),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .out_res    (outRes),
        .out_zero   (outZero),
        .out_parity (outParity)
`ifdef LOGIC_UNIT_POPCNT_EN
        ,
        .out_popcnt (outPop)
`endif
    );

    // ---------------- WIDTH=8 instance ----------------
    logic       inValid8, inReady8, outValid8, outReady8, outZero8, outParity8;
    logic [0:7] inA8, inB8, outRes8;
    logic [2:0] inOp8;
`ifdef LOGIC_UNIT_POPCNT_EN
    logic [PW8-1:0] outPop8;
`endif

    logic_unit_pipe #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (inValid8),
        .in_ready   (inReady8),
        .in_a       (inA8),
        .in_b       (inB8),
        .in_op      (inOp8),
        .out_valid  (outValid8),
        .out_ready  (outReady8),
        .out_res    (outRes8),
        .out_zero   (outZero8),
        .out_parity (outParity8)
`ifdef LOGIC_UNIT_POPCNT_EN
        ,
        .out_popcnt (outPop8)
`endif
    );

    typedef struct {
        logic [0:31] a;
        logic [0:31] b;
        lopE         op;
        logic [0:31] res;
        logic        zero;
        logic        parity;
    } vecT;

    typedef struct {
        logic [0:31] res;
        logic        zero;
        logic        parity;
        int          pop;
        int          cyc;
        bit          chkLat;
    } expT;

    expT expQ[$];
    expT expQ8[$];
    int  validHigh    = 0;
    bit  sawInRdyLow  = 1'b0;
    int  validHigh8   = 0;

    // ---------------- Monitor / scoreboard, WIDTH=32 ----------------
    logic        prevStall = 1'b0;
    logic [0:31] prevRes;
    logic        prevZ, prevP;

    always @(negedge clk) begin
        expT e;
        if (!rst_n) begin
            expQ.delete();
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                chk("stall_valid32", 64'(outValid), 64'(1));
                chk("stall_res32", 64'(outRes), 64'(prevRes));
                chk("stall_flags32", 64'({outZero, outParity}), 64'({prevZ, prevP}));
            end
            if (!inReady) begin
                sawInRdyLow = 1'b1;
                chk("in_ready_low32", 64'(outValid && !outReady), 64'(1));
            end
            if (outValid) validHigh++;
            if (outValid && outReady) begin
                if (expQ.size() == 0) begin
                    chk("unexpected_out32", 64'(outRes), 64'(0));
                    if (outRes == 32'h0) begin
                        errors++;
                        $display("FAIL unexpected_out32: got out_valid=1, expected no beat");
                    end
                end else begin
                    e = expQ.pop_front();
                    chk("res32", 64'(outRes), 64'(e.res));
                    chk("zero32", 64'(outZero), 64'(e.zero));
                    chk("parity32", 64'(outParity), 64'(e.parity));
`ifdef LOGIC_UNIT_POPCNT_EN
                    chk("popcnt32", 64'(outPop), 64'(e.pop));
`endif
                    if (e.chkLat) chk("latency32", 64'(cyc - e.cyc), 64'(2));
                end
            end
            prevStall = outValid && !outReady;
            prevRes   = outRes;
            prevZ     = outZero;
            prevP     = outParity;
        end
    end

    // ---------------- Monitor / scoreboard, WIDTH=8 ----------------
    logic       prevStall8 = 1'b0;
    logic [0:7] prevRes8;
    logic       prevZ8, prevP8;

    always @(negedge clk) begin
        expT e;
        if (!rst_n) begin
            expQ8.delete();
            prevStall8 = 1'b0;
        end else begin
            if (prevStall8) begin
                chk("stall_valid8", 64'(outValid8), 64'(1));
                chk("stall_res8", 64'(outRes8), 64'(prevRes8));
                chk("stall_flags8", 64'({outZero8, outParity8}), 64'({prevZ8, prevP8}));
            end
            if (!inReady8) chk("in_ready_low8", 64'(outValid8 && !outReady8), 64'(1));
            if (outValid8) validHigh8++;
            if (outValid8 && outReady8) begin
                if (expQ8.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_out8: got out_valid=1 res=%h, expected no beat",
                             outRes8);
                end else begin
                    e = expQ8.pop_front();
                    chk("res8", 64'(outRes8), 64'(e.res[24:31]));
                    chk("zero8", 64'(outZero8), 64'(e.zero));
                    chk("parity8", 64'(outParity8), 64'(e.parity));
`ifdef LOGIC_UNIT_POPCNT_EN
                    chk("popcnt8", 64'(outPop8), 64'(e.pop));
`endif
                end
            end
            prevStall8 = outValid8 && !outReady8;
            prevRes8   = outRes8;
            prevZ8     = outZero8;
            prevP8     = outParity8;
        end
    end

    // ---------------- Drivers ----------------
    task automatic send32(input vecT v, input bit lat);
        expT e;
        bit  acc = 1'b0;
        inValid = 1'b1;
        inA     = v.a;
        inB     = v.b;
        inOp    = v.op;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            if (inReady) acc = 1'b1;
        end
        if (acc) begin
            e.res = v.res;  e.zero = v.zero;  e.parity = v.parity;
            e.pop = $countones(v.res);  e.cyc = cyc;  e.chkLat = lat;
            expQ.push_back(e);
        end else begin
            chk("send_timeout32", 64'(inReady), 64'(1));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic [0:7] a, input logic [0:7] b, input logic [2:0] op);
        expT         e;
        logic [63:0] r;
        bit          acc = 1'b0;
        inValid8 = 1'b1;
        inA8     = a;
        inB8     = b;
        inOp8    = op;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            if (inReady8) acc = 1'b1;
        end
        if (acc) begin
            r = modelRes({56'h0, a}, {56'h0, b}, op);
            e.res = {24'h0, r[7:0]};  e.zero = ~|r[7:0];  e.parity = ^r[7:0];
            e.pop = $countones(r[7:0]);  e.cyc = cyc;  e.chkLat = 1'b0;
            expQ8.push_back(e);
        end else begin
            chk("send_timeout8", 64'(inReady8), 64'(1));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        int t = 0;
        while ((expQ.size() != 0 || expQ8.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk(nm, 64'(expQ.size() + expQ8.size()), 64'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic vecT mkVec(input logic [0:31] a, input logic [0:31] b, input lopE op);
        vecT         v;
        logic [63:0] r;
        r = modelRes({32'h0, a}, {32'h0, b}, op);
        v.a = a;  v.b = b;  v.op = op;
        v.res = r[31:0];  v.zero = ~|r[31:0];  v.parity = ^r[31:0];
        return v;
    endfunction

    vecT vecs[11];
    bit  done8 = 1'b0;

    initial begin
        int v0;

        vecs[0]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, LOP_AND,   32'hF000_F000, 1'b0, 1'b0};
        vecs[1]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, LOP_OR,    32'hFFF0_FFF0, 1'b0, 1'b0};
        vecs[2]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, LOP_XOR,   32'h0FF0_0FF0, 1'b0, 1'b0};
        vecs[3]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, LOP_NOR,   32'h000F_000F, 1'b0, 1'b0};
        vecs[4]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, LOP_NAND,  32'h0FFF_0FFF, 1'b0, 1'b0};
        vecs[5]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, LOP_XNOR,  32'hF00F_F00F, 1'b0, 1'b0};
        vecs[6]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, LOP_ANDN,  32'h00F0_00F0, 1'b0, 1'b0};
        vecs[7]  = '{32'hF0F0_F0F0, 32'hFF00_FF00, LOP_PASSA, 32'hF0F0_F0F0, 1'b0, 1'b0};
        vecs[8]  = '{32'h1234_5678, 32'h1234_5678, LOP_XOR,   32'h0000_0000, 1'b1, 1'b0};
        vecs[9]  = '{32'h0000_0001, 32'h0000_0000, LOP_OR,    32'h0000_0001, 1'b0, 1'b1};
        vecs[10] = '{32'h8000_0000, 32'h0000_0000, LOP_PASSA, 32'h8000_0000, 1'b0, 1'b1};

        rst_n    = 1'b0;
        inValid  = 1'b0;  inA  = '0;  inB  = '0;  inOp  = '0;  outReady  = 1'b1;
        inValid8 = 1'b0;  inA8 = '0;  inB8 = '0;  inOp8 = '0;  outReady8 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 64'(outValid), 64'(0));
        chk("rst_in_ready", 64'(inReady), 64'(1));
        chk("rst_out_res", 64'(outRes), 64'(0));
        chk("rst_out_zero", 64'(outZero), 64'(1));
        chk("rst_out_parity", 64'(outParity), 64'(0));
        chk("rst_in_ready8", 64'(inReady8), 64'(1));
`ifdef LOGIC_UNIT_POPCNT_EN
        chk("rst_popcnt", 64'(outPop), 64'(0));
`endif
        @(posedge clk);
        #1;

        // Opcode sweep back-to-back: latency 2, out_valid continuous
        v0 = validHigh;
        for (int i = 0; i < 8; i++) send32(vecs[i], 1'b1);
        inValid = 1'b0;
        drain("drain_sweep");
        chk("sweep_valid_cycles", 64'(validHigh - v0), 64'(8));

        // Flag vectors
        for (int i = 8; i < 10; i++) send32(vecs[i], 1'b1);
        inValid = 1'b0;
        drain("drain_flags");

        // Bit ordering: bit 0 is MSB
        send32(vecs[10], 1'b1);
        inValid = 1'b0;
        repeat (2) @(negedge clk);
        chk("bitorder_valid", 64'(outValid), 64'(1));
        chk("bitorder_msb", 64'(outRes[0]), 64'(1));
        chk("bitorder_lsb", 64'(outRes[31]), 64'(0));
        drain("drain_bitorder");

        // Backpressure: 6 beats, out_ready low 4 cycles mid-stream
        sawInRdyLow = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send32(mkVec(32'h1111_1111 * (i + 1), 32'h0F3C_A5E1 ^ (i * 32'h0101_0101),
                                 lopE'(3'(i))), 1'b0);
                inValid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 outReady = 1'b0;
                repeat (4) @(posedge clk);
                #1 outReady = 1'b1;
            end
        join
        drain("drain_backpressure");
        chk("bp_in_ready_fell", 64'(sawInRdyLow), 64'(1));

        // Reset with 2 beats in flight
        send32(mkVec(32'hDEAD_BEEF, 32'h0000_FFFF, LOP_AND), 1'b0);
        send32(mkVec(32'hCAFE_F00D, 32'hFFFF_0000, LOP_XOR), 1'b0);
        inValid = 1'b0;
        rst_n   = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 64'(outValid), 64'(0));
        chk("midrst_in_ready", 64'(inReady), 64'(1));
        v0 = validHigh;
        repeat (5) @(negedge clk);
        chk("midrst_no_stale", 64'(validHigh - v0), 64'(0));
        @(posedge clk);
        #1;

        // WIDTH=8 random traffic with random out_ready
        fork
            begin
                for (int n = 0; n < 1000; n++) begin
                    if ($urandom_range(3) == 0) begin
                        inValid8 = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    send8(8'($urandom), 8'($urandom), 3'($urandom_range(7)));
                end
                inValid8 = 1'b0;
                done8    = 1'b1;
            end
            begin
                while (!done8) begin
                    @(posedge clk);
                    #1 outReady8 = 1'($urandom_range(1));
                end
                outReady8 = 1'b1;
            end
        join
        drain("drain_random8");
        chk("random8_beats", 64'(validHigh8 >= 1000), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
